// File: rtl/retire_trace_checker.sv
// Multi-lane retire checker: buffers golden register-write records and compares DUT
// retirements against them in program order, holding sticky PASS/FAIL and the first error.
module retire_trace_checker #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     LANES      = 2,
  parameter int unsigned     FIFO_DEPTH = 8,
  parameter logic [XLEN-1:0] END_ADDR   = XLEN'('h0C),
  parameter int unsigned     CNT_W      = 32
) (
  input  logic                                       sys_clk,
  input  logic                                       sys_reset_n,
  input  logic                                       gold_valid,
  output logic                                       gold_ready,
  input  logic                                       gold_last,
  input  logic [XLEN-1:0]                            gold_pc,
  input  logic [4:0]                                 gold_waddr,
  input  logic [XLEN-1:0]                            gold_wdata,
  input  logic [XLEN-1:0]                            gold_mask,
  input  logic [LANES-1:0]                           rt_valid,
  input  logic [LANES*XLEN-1:0]                      rt_pc,
  input  logic [LANES*5-1:0]                         rt_waddr,
  input  logic [LANES*XLEN-1:0]                      rt_wdata,
  input  logic                                       mem_wen,
  input  logic [XLEN-1:0]                            mem_addr,
  input  logic [XLEN-1:0]                            mem_wdata,
  output logic                                       chk_pass,
  output logic                                       chk_fail,
  output logic [1:0]                                 fail_code,
  output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] err_lane,
  output logic [XLEN-1:0]                            err_pc,
  output logic [XLEN-1:0]                            err_wdata,
  output logic [XLEN-1:0]                            err_gold_pc,
  output logic [XLEN-1:0]                            err_gold_wdata,
  output logic [CNT_W-1:0]                           retire_cnt
);

  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] CODE_MISMATCH  = 2'd1;
  localparam logic [1:0] CODE_UNDERFLOW = 2'd2;
  localparam logic [1:0] CODE_EARLY_END = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PASS,
    ST_FAIL
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     headPtr_q, headPtr_d;
  logic [AW-1:0]     tailPtr_q, tailPtr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              lastSeen_q, lastSeen_d;
  logic [CNT_W-1:0]  retireCnt_q, retireCnt_d;
  logic [1:0]        failCode_q, failCode_d;
  logic [LW-1:0]     errLane_q, errLane_d;
  logic [XLEN-1:0]   errPc_q, errPc_d;
  logic [XLEN-1:0]   errWdata_q, errWdata_d;
  logic [XLEN-1:0]   errGoldPc_q, errGoldPc_d;
  logic [XLEN-1:0]   errGoldWdata_q, errGoldWdata_d;

  logic [XLEN-1:0]   fifoPc_q    [FIFO_DEPTH];
  logic [4:0]        fifoWaddr_q [FIFO_DEPTH];
  logic [XLEN-1:0]   fifoWdata_q [FIFO_DEPTH];
  logic [XLEN-1:0]   fifoMask_q  [FIFO_DEPTH];

  logic [XLEN-1:0]   lanePc    [LANES];
  logic [4:0]        laneWaddr [LANES];
  logic [XLEN-1:0]   laneWdata [LANES];
  logic [LANES-1:0]  laneEff;

  for (genvar g = 0; g < LANES; g++) begin : gLane
    assign lanePc[g]    = rt_pc[g*XLEN +: XLEN];
    assign laneWaddr[g] = rt_waddr[g*5 +: 5];
    assign laneWdata[g] = rt_wdata[g*XLEN +: XLEN];
    assign laneEff[g]   = rt_valid[g] & (rt_waddr[g*5 +: 5] != 5'd0);
  end

  logic pushAcc;
  logic pushStore;
  logic endCond;

  assign gold_ready = (state_q == ST_RUN) && (count_q < CW'(FIFO_DEPTH)) && !lastSeen_q;
  assign pushAcc    = gold_valid & gold_ready;
  assign pushStore  = pushAcc & (gold_waddr != 5'd0);
  assign endCond    = mem_wen & (mem_addr == END_ADDR) & (mem_wdata == '0);

  // The k-th effective lane is checked against entry head+k; the first failing lane wins,
  // and a lane with no buffered record is reported as underflow before any compare.
  logic [CW-1:0]   effCnt;
  logic [AW-1:0]   entryIdx;
  logic            laneOk;
  logic            errFound;
  logic            errUnder;
  logic [LW-1:0]   errLaneC;
  logic [XLEN-1:0] errPcC, errWdataC, errGoldPcC, errGoldWdataC;

  always_comb begin
    effCnt        = '0;
    entryIdx      = '0;
    laneOk        = 1'b1;
    errFound      = 1'b0;
    errUnder      = 1'b0;
    errLaneC      = '0;
    errPcC        = '0;
    errWdataC     = '0;
    errGoldPcC    = '0;
    errGoldWdataC = '0;
    for (int i = 0; i < LANES; i++) begin
      if (laneEff[i]) begin
        entryIdx = headPtr_q + effCnt[AW-1:0];
        laneOk   = (lanePc[i] == fifoPc_q[entryIdx]) &&
                   (laneWaddr[i] == fifoWaddr_q[entryIdx]) &&
                   ((laneWdata[i] & fifoMask_q[entryIdx]) ==
                    (fifoWdata_q[entryIdx] & fifoMask_q[entryIdx]));
        if (!errFound && (effCnt >= count_q)) begin
          errFound  = 1'b1;
          errUnder  = 1'b1;
          errLaneC  = LW'(i);
          errPcC    = lanePc[i];
          errWdataC = laneWdata[i];
        end else if (!errFound && !laneOk) begin
          errFound      = 1'b1;
          errLaneC      = LW'(i);
          errPcC        = lanePc[i];
          errWdataC     = laneWdata[i];
          errGoldPcC    = fifoPc_q[entryIdx];
          errGoldWdataC = fifoWdata_q[entryIdx];
        end
        effCnt = effCnt + 1'b1;
      end
    end
  end

  logic [CW-1:0]  popCnt;
  logic [CNT_W:0] cntSum;

  always_comb begin
    state_d        = state_q;
    headPtr_d      = headPtr_q;
    tailPtr_d      = tailPtr_q;
    count_d        = count_q;
    lastSeen_d     = lastSeen_q;
    retireCnt_d    = retireCnt_q;
    failCode_d     = failCode_q;
    errLane_d      = errLane_q;
    errPc_d        = errPc_q;
    errWdata_d     = errWdata_q;
    errGoldPc_d    = errGoldPc_q;
    errGoldWdata_d = errGoldWdata_q;
    popCnt         = '0;
    cntSum         = '0;
    if (state_q == ST_RUN) begin
      if (pushAcc && gold_last) begin
        lastSeen_d = 1'b1;
      end
      if (pushStore) begin
        tailPtr_d = tailPtr_q + 1'b1;
      end
      if (errFound) begin
        state_d        = ST_FAIL;
        failCode_d     = errUnder ? CODE_UNDERFLOW : CODE_MISMATCH;
        errLane_d      = errLaneC;
        errPc_d        = errPcC;
        errWdata_d     = errWdataC;
        errGoldPc_d    = errGoldPcC;
        errGoldWdata_d = errGoldWdataC;
      end else begin
        popCnt      = effCnt;
        headPtr_d   = headPtr_q + effCnt[AW-1:0];
        cntSum      = {1'b0, retireCnt_q} + (CNT_W+1)'(effCnt);
        retireCnt_d = cntSum[CNT_W] ? '1 : cntSum[CNT_W-1:0];
        // End is judged on the registered occupancy, so records retired this cycle still count.
        if (endCond) begin
          if (lastSeen_q && (count_q == '0)) begin
            state_d = ST_PASS;
          end else begin
            state_d    = ST_FAIL;
            failCode_d = CODE_EARLY_END;
          end
        end
      end
      count_d = count_q + CW'(pushStore) - popCnt;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (pushStore) begin
      fifoPc_q[tailPtr_q]    <= gold_pc;
      fifoWaddr_q[tailPtr_q] <= gold_waddr;
      fifoWdata_q[tailPtr_q] <= gold_wdata;
      fifoMask_q[tailPtr_q]  <= gold_mask;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q        <= ST_RUN;
      headPtr_q      <= '0;
      tailPtr_q      <= '0;
      count_q        <= '0;
      lastSeen_q     <= 1'b0;
      retireCnt_q    <= '0;
      failCode_q     <= '0;
      errLane_q      <= '0;
      errPc_q        <= '0;
      errWdata_q     <= '0;
      errGoldPc_q    <= '0;
      errGoldWdata_q <= '0;
    end else begin
      state_q        <= state_d;
      headPtr_q      <= headPtr_d;
      tailPtr_q      <= tailPtr_d;
      count_q        <= count_d;
      lastSeen_q     <= lastSeen_d;
      retireCnt_q    <= retireCnt_d;
      failCode_q     <= failCode_d;
      errLane_q      <= errLane_d;
      errPc_q        <= errPc_d;
      errWdata_q     <= errWdata_d;
      errGoldPc_q    <= errGoldPc_d;
      errGoldWdata_q <= errGoldWdata_d;
    end
  end

  assign chk_pass       = (state_q == ST_PASS);
  assign chk_fail       = (state_q == ST_FAIL);
  assign fail_code      = failCode_q;
  assign err_lane       = errLane_q;
  assign err_pc         = errPc_q;
  assign err_wdata      = errWdata_q;
  assign err_gold_pc    = errGoldPc_q;
  assign err_gold_wdata = errGoldWdata_q;
  assign retire_cnt     = retireCnt_q;

endmodule

// File: tb/tb_retire_trace_checker.sv
// Bench for retire_trace_checker: directed scenarios plus randomized episodes, all compared
// against a queue-based reference model of the golden trace and the checker's status.
module tb_retire_trace_checker;

  localparam int XLEN  = 32;
  localparam int LANES = 2;
  localparam int DEPTH = 8;
  localparam int CNT_W = 32;
  localparam logic [31:0] END_ADDR = 32'h0C;

  logic                  sys_clk;
  logic                  sys_reset_n;
  logic                  gold_valid, gold_ready, gold_last;
  logic [XLEN-1:0]       gold_pc, gold_wdata, gold_mask;
  logic [4:0]            gold_waddr;
  logic [LANES-1:0]      rt_valid;
  logic [LANES*XLEN-1:0] rt_pc, rt_wdata;
  logic [LANES*5-1:0]    rt_waddr;
  logic                  mem_wen;
  logic [XLEN-1:0]       mem_addr, mem_wdata;
  logic                  chk_pass, chk_fail;
  logic [1:0]            fail_code;
  logic [0:0]            err_lane;
  logic [XLEN-1:0]       err_pc, err_wdata, err_gold_pc, err_gold_wdata;
  logic [CNT_W-1:0]      retire_cnt;

  retire_trace_checker #(
    .XLEN(XLEN), .LANES(LANES), .FIFO_DEPTH(DEPTH), .END_ADDR(END_ADDR), .CNT_W(CNT_W)
  ) dut (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n),
    .gold_valid(gold_valid), .gold_ready(gold_ready), .gold_last(gold_last),
    .gold_pc(gold_pc), .gold_waddr(gold_waddr), .gold_wdata(gold_wdata), .gold_mask(gold_mask),
    .rt_valid(rt_valid), .rt_pc(rt_pc), .rt_waddr(rt_waddr), .rt_wdata(rt_wdata),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .chk_pass(chk_pass), .chk_fail(chk_fail), .fail_code(fail_code), .err_lane(err_lane),
    .err_pc(err_pc), .err_wdata(err_wdata), .err_gold_pc(err_gold_pc),
    .err_gold_wdata(err_gold_wdata), .retire_cnt(retire_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] mask;
  } rec_t;

  // Reference model: golden trace as a queue, status 0 running / 1 pass / 2 fail.
  rec_t        mQ[$];
  int          mStatus;
  bit          mLast;
  logic [1:0]  mCode;
  logic [0:0]  mLane;
  logic [31:0] mErrPc, mErrWd, mErrGpc, mErrGwd, mCnt;

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  function automatic void modelReset();
    mQ.delete();
    mStatus = 0; mLast = 1'b0; mCode = 2'd0; mLane = 1'b0;
    mErrPc = '0; mErrWd = '0; mErrGpc = '0; mErrGwd = '0; mCnt = '0;
  endfunction

  function automatic bit modelReady();
    return (mStatus == 0) && (mQ.size() < DEPTH) && !mLast;
  endfunction

  // One clock of the model, evaluated on the inputs about to be sampled.
  function automatic void modelStep();
    int   k = 0;
    int   preSize;
    bit   err = 1'b0;
    bit   accept;
    rec_t r;
    logic [31:0] pc, wd;
    logic [4:0]  wa;
    if (mStatus != 0) return;
    accept  = gold_valid && modelReady();
    preSize = mQ.size();
    for (int l = 0; l < LANES; l++) begin
      pc = rt_pc[l*XLEN +: XLEN];
      wa = rt_waddr[l*5 +: 5];
      wd = rt_wdata[l*XLEN +: XLEN];
      if (rt_valid[l] && wa != 5'd0) begin
        if (!err) begin
          if (k >= preSize) begin
            err = 1'b1; mCode = 2'd2; mLane = 1'(l);
            mErrPc = pc; mErrWd = wd; mErrGpc = '0; mErrGwd = '0;
          end else begin
            r = mQ[k];
            if (pc != r.pc || wa != r.waddr || (wd & r.mask) != (r.wdata & r.mask)) begin
              err = 1'b1; mCode = 2'd1; mLane = 1'(l);
              mErrPc = pc; mErrWd = wd; mErrGpc = r.pc; mErrGwd = r.wdata;
            end
          end
        end
        k++;
      end
    end
    if (err) begin
      mStatus = 2;
    end else begin
      for (int j = 0; j < k; j++) void'(mQ.pop_front());
      mCnt = mCnt + 32'(k);
      if (mem_wen && mem_addr == END_ADDR && mem_wdata == 32'd0) begin
        if (mLast && preSize == 0) mStatus = 1;
        else begin mStatus = 2; mCode = 2'd3; end
      end
    end
    if (accept) begin
      if (gold_waddr != 5'd0) begin
        r.pc = gold_pc; r.waddr = gold_waddr; r.wdata = gold_wdata; r.mask = gold_mask;
        mQ.push_back(r);
      end
      if (gold_last) mLast = 1'b1;
    end
  endfunction

  task automatic checkState();
    checkOutput("gold_ready",     64'(gold_ready),     64'(modelReady()));
    checkOutput("chk_pass",       64'(chk_pass),       64'(mStatus == 1));
    checkOutput("chk_fail",       64'(chk_fail),       64'(mStatus == 2));
    checkOutput("fail_code",      64'(fail_code),      64'(mCode));
    checkOutput("err_lane",       64'(err_lane),       64'(mLane));
    checkOutput("err_pc",         64'(err_pc),         64'(mErrPc));
    checkOutput("err_wdata",      64'(err_wdata),      64'(mErrWd));
    checkOutput("err_gold_pc",    64'(err_gold_pc),    64'(mErrGpc));
    checkOutput("err_gold_wdata", 64'(err_gold_wdata), 64'(mErrGwd));
    checkOutput("retire_cnt",     64'(retire_cnt),     64'(mCnt));
  endtask

  task automatic idleInputs();
    gold_valid = 1'b0; gold_last = 1'b0; gold_pc = '0; gold_waddr = '0;
    gold_wdata = '0; gold_mask = '0;
    rt_valid = '0; rt_pc = '0; rt_waddr = '0; rt_wdata = '0;
    mem_wen = 1'b0; mem_addr = '0; mem_wdata = '0;
  endtask

  task automatic setGold(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [31:0] mask, input bit last);
    gold_valid = 1'b1; gold_pc = pc; gold_waddr = wa; gold_wdata = wd;
    gold_mask = mask; gold_last = last;
  endtask

  task automatic setLane(input int l, input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] wd);
    rt_valid[l] = 1'b1;
    rt_pc[l*XLEN +: XLEN] = pc;
    rt_waddr[l*5 +: 5] = wa;
    rt_wdata[l*XLEN +: XLEN] = wd;
  endtask

  task automatic setEnd();
    mem_wen = 1'b1; mem_addr = END_ADDR; mem_wdata = '0;
  endtask

  // Advance one clock with the currently driven inputs, then compare against the model.
  task automatic applyStimulus();
    modelStep();
    @(posedge sys_clk);
    #1;
    checkState();
  endtask

  task automatic doReset();
    idleInputs();
    sys_reset_n = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_gold_ready", 64'(gold_ready), 64'd1);
    checkOutput("rst_chk_fail",   64'(chk_fail),   64'd0);
    checkOutput("rst_chk_pass",   64'(chk_pass),   64'd0);
    checkOutput("rst_retire_cnt", 64'(retire_cnt), 64'd0);
    @(posedge sys_clk);
    #1;
    sys_reset_n = 1'b1;
  endtask

  // Random push plus retires that follow the model's trace; skipped lanes carry junk.
  task automatic randomStimulus();
    int avail;
    int k = 0;
    int r;
    idleInputs();
    if ($urandom_range(0, 9) < 6) begin
      setGold($urandom, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom,
              ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom, 1'b0);
    end
    avail = mQ.size();
    for (int l = 0; l < LANES; l++) begin
      r = int'($urandom_range(0, 3));
      if (r >= 1 && k < avail) begin
        setLane(l, mQ[k].pc, mQ[k].waddr, mQ[k].wdata ^ ($urandom & ~mQ[k].mask));
        k++;
      end else if (r == 0) begin
        rt_pc[l*XLEN +: XLEN] = $urandom;
        rt_wdata[l*XLEN +: XLEN] = $urandom;
        if ($urandom_range(0, 1) == 1) begin
          rt_valid[l] = 1'b1; rt_waddr[l*5 +: 5] = 5'd0;
        end else begin
          rt_valid[l] = 1'b0; rt_waddr[l*5 +: 5] = 5'($urandom);
        end
      end
    end
  endtask

  task automatic drain();
    for (int d = 0; d < DEPTH && mQ.size() > 0; d++) begin
      idleInputs();
      for (int l = 0; l < LANES && l < mQ.size(); l++) setLane(l, mQ[l].pc, mQ[l].waddr, mQ[l].wdata);
      applyStimulus();
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nCyc;
    int mode;
    doReset();

    // Two records retired together on lanes 0/1.
    idleInputs(); setGold(32'h0, 5'd1, 32'h5, 32'hFFFF_FFFF, 1'b0); applyStimulus();
    idleInputs(); setGold(32'h4, 5'd2, 32'h7, 32'hFFFF_FFFF, 1'b0); applyStimulus();
    idleInputs(); setLane(0, 32'h0, 5'd1, 32'h5); setLane(1, 32'h4, 5'd2, 32'h7); applyStimulus();
    checkOutput("t1_retire_cnt", 64'(retire_cnt), 64'd2);
    checkOutput("t1_chk_fail", 64'(chk_fail), 64'd0);

    // Masked compare: upper nibble ignored, lower nibble differences caught.
    idleInputs(); setGold(32'h8, 5'd3, 32'hFF, 32'h0F, 1'b0); applyStimulus();
    idleInputs(); setGold(32'hC, 5'd3, 32'hFF, 32'h0F, 1'b0);
    setLane(0, 32'h8, 5'd3, 32'h1F); applyStimulus();
    checkOutput("t2_masked_ok", 64'(chk_fail), 64'd0);
    idleInputs(); setLane(0, 32'hC, 5'd3, 32'h1E); applyStimulus();
    checkOutput("t2_code", 64'(fail_code), 64'd1);
    checkOutput("t2_lane", 64'(err_lane), 64'd0);
    checkOutput("t2_wdata", 64'(err_wdata), 64'h1E);

    // Underflow on lane 1 with lane 0 skipped (waddr 0).
    doReset();
    idleInputs(); setLane(0, 32'h40, 5'd0, 32'h1); setLane(1, 32'h44, 5'd4, 32'h2); applyStimulus();
    checkOutput("t3_code", 64'(fail_code), 64'd2);
    checkOutput("t3_lane", 64'(err_lane), 64'd1);

    // Full FIFO back-pressure; waddr 0 records take no slot.
    doReset();
    for (int i = 0; i < DEPTH; i++) begin
      idleInputs(); setGold(32'(i * 4), 5'(i + 1), 32'(i), 32'hFFFF_FFFF, 1'b0); applyStimulus();
    end
    checkOutput("t4_full_ready", 64'(gold_ready), 64'd0);
    idleInputs(); setLane(0, 32'h0, 5'd1, 32'h0); applyStimulus();
    checkOutput("t4_ready_after_pop", 64'(gold_ready), 64'd1);
    idleInputs(); setGold(32'h100, 5'd0, 32'h0, 32'hFFFF_FFFF, 1'b0); applyStimulus();
    checkOutput("t4_zero_dropped", 64'(gold_ready), 64'd1);
    idleInputs(); setGold(32'h104, 5'd9, 32'h0, 32'hFFFF_FFFF, 1'b0); applyStimulus();
    checkOutput("t4_full_again", 64'(gold_ready), 64'd0);

    // Clean end of trace, then an early end.
    doReset();
    idleInputs(); setGold(32'h10, 5'd5, 32'h55, 32'hFFFF_FFFF, 1'b1); applyStimulus();
    checkOutput("t5_ready_after_last", 64'(gold_ready), 64'd0);
    idleInputs(); setLane(0, 32'h10, 5'd5, 32'h55); applyStimulus();
    idleInputs(); setEnd(); applyStimulus();
    checkOutput("t5_pass", 64'(chk_pass), 64'd1);
    doReset();
    idleInputs(); setEnd(); applyStimulus();
    checkOutput("t5_early_code", 64'(fail_code), 64'd3);

    // Asynchronous reset with the FIFO half full.
    doReset();
    for (int i = 0; i < DEPTH / 2; i++) begin
      idleInputs(); setGold(32'(i * 4), 5'd6, 32'(i), 32'hFFFF_FFFF, 1'b0); applyStimulus();
    end
    doReset();
    idleInputs(); setLane(0, 32'h0, 5'd6, 32'h0); applyStimulus();
    checkOutput("t6_fifo_emptied", 64'(fail_code), 64'd2);

    // Randomized episodes, each ending in a pass or an injected failure.
    for (int ep = 0; ep < 24; ep++) begin
      mode = ep % 4;
      doReset();
      nCyc = int'($urandom_range(15, 40));
      for (int c = 0; c < nCyc; c++) begin
        randomStimulus();
        applyStimulus();
      end
      case (mode)
        0: begin
          drain();
          idleInputs(); setGold(32'h1000, 5'd1, 32'h1, 32'hFFFF_FFFF, 1'b1); applyStimulus();
          idleInputs(); setLane(0, 32'h1000, 5'd1, 32'h1); applyStimulus();
          idleInputs(); setEnd(); applyStimulus();
          checkOutput("ep_pass", 64'(chk_pass), 64'd1);
        end
        1: begin
          if (mQ.size() == 0) begin
            idleInputs(); setGold(32'h2000, 5'd7, 32'h3, 32'hFFFF_FFFF, 1'b0); applyStimulus();
          end
          idleInputs(); setLane(0, mQ[0].pc ^ 32'h4, mQ[0].waddr, mQ[0].wdata); applyStimulus();
          checkOutput("ep_mismatch_code", 64'(fail_code), 64'd1);
        end
        2: begin
          drain();
          idleInputs(); setLane(1, 32'h3000, 5'd9, 32'h9); applyStimulus();
          checkOutput("ep_underflow_code", 64'(fail_code), 64'd2);
          checkOutput("ep_underflow_lane", 64'(err_lane), 64'd1);
        end
        default: begin
          idleInputs(); setEnd(); applyStimulus();
          checkOutput("ep_early_code", 64'(fail_code), 64'd3);
        end
      endcase
      for (int c = 0; c < 3; c++) begin
        randomStimulus();
        mem_wen = 1'($urandom);
        mem_addr = ($urandom_range(0, 1) == 1) ? END_ADDR : $urandom;
        applyStimulus();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
